// File: rtl/dcache_req_responder_pkg.sv
// Shared types and constants for the data-cache request responder.
package dcache_req_responder_pkg;

  localparam int LINE_WORDS = 32;
  localparam int SET_BITS   = 5;
  localparam int TAG_BITS   = 19;

  localparam logic [1:0] DC_OP_BYTE = 2'd0;
  localparam logic [1:0] DC_OP_HALF = 2'd1;
  localparam logic [1:0] DC_OP_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    BUSREQ,
    BEATS,
    TAGW,
    DONE
  } state_e;

endpackage

// File: rtl/dc_lane_extract.sv
// Picks the addressed byte/half/word out of a bus word and right-justifies it,
// zero-filling the upper bits.
module dc_lane_extract
  import dcache_req_responder_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    // NOTE: data_o gets a value before the case so no path through this block
    // leaves it unassigned; otherwise synthesis would infer a latch.
    data_o = rdata_i;
    case (op_i)
      DC_OP_BYTE: data_o = {24'b0, byte_lane};
      DC_OP_HALF: data_o = {16'b0, half_lane};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dcache_req_responder.sv
// Data-cache miss responder: serves a load-queue request either as one uncached
// bus read or as a full line refill into the data BRAM followed by a tag write.
module dcache_req_responder #(
  parameter int LINE_WORDS = dcache_req_responder_pkg::LINE_WORDS,
  parameter int WAYS       = 2
) (
  input  logic        core_clock_i,
  input  logic        core_reset_i,
  input  logic        dc_req,
  input  logic [31:0] dc_addr,
  input  logic [1:0]  dc_op,
  input  logic        dc_uncached,
  output logic [31:0] dc_data,
  output logic        dc_cmp,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_burst_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        bram_wr_en_o,
  output logic [10:0] bram_wr_addr_o,
  output logic [31:0] bram_wr_data_o,
  output logic        tag_wr_en_o,
  output logic [4:0]  tag_wr_set_o,
  output logic        tag_wr_way_o,
  output logic [18:0] tag_wr_tag_o
);
  import dcache_req_responder_pkg::*;

  localparam int BEAT_BITS = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int OFF_BITS  = BEAT_BITS + 2;
  localparam int NUM_SETS  = 1 << SET_BITS;

  state_e state_q, state_d;

  logic [31:0]                        addr_q, addr_d;
  logic [1:0]                         op_q, op_d;
  logic                               unc_q, unc_d;
  logic [WAY_BITS-1:0]                victim_q, victim_d;
  logic [BEAT_BITS-1:0]               beat_q, beat_d;
  logic [NUM_SETS-1:0][WAY_BITS-1:0]  rr_q, rr_d;
  logic                               cooldown_q, cooldown_d;
  logic [31:0]                        dc_data_q, dc_data_d;
  logic                               dc_cmp_q, dc_cmp_d;
  logic                               mem_req_q, mem_req_d;
  logic                               bram_wr_en_q, bram_wr_en_d;
  logic [10:0]                        bram_wr_addr_q, bram_wr_addr_d;
  logic [31:0]                        bram_wr_data_q, bram_wr_data_d;
  logic                               tag_wr_en_q, tag_wr_en_d;

  logic [SET_BITS-1:0] req_set, cur_set;
  logic [31:0]         lane_data;
  logic                beat_fire, last_beat;

  assign req_set   = dc_addr[OFF_BITS +: SET_BITS];
  assign cur_set   = addr_q[OFF_BITS +: SET_BITS];
  assign beat_fire = (state_q == BEATS) && mem_rvalid_i;
  assign last_beat = (beat_q == BEAT_BITS'(LINE_WORDS - 1));

  dc_lane_extract u_lane (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (mem_rdata_i),
    .data_o    (lane_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dc_req && !cooldown_q) state_d = BUSREQ;
      BUSREQ:  if (mem_gnt_i) state_d = BEATS;
      BEATS: begin
        if (mem_rvalid_i) begin
          if (unc_q)          state_d = DONE;
          else if (last_beat) state_d = TAGW;
        end
      end
      TAGW:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d         = addr_q;
    op_d           = op_q;
    unc_d          = unc_q;
    victim_d       = victim_q;
    beat_d         = beat_q;
    rr_d           = rr_q;
    dc_data_d      = dc_data_q;
    bram_wr_addr_d = bram_wr_addr_q;
    bram_wr_data_d = bram_wr_data_q;

    // Request fields are captured only on acceptance; later input changes are ignored.
    if (state_q == IDLE && state_d == BUSREQ) begin
      addr_d   = dc_addr;
      op_d     = dc_op;
      unc_d    = dc_uncached;
      victim_d = rr_q[req_set];
    end

    bram_wr_en_d = beat_fire && !unc_q;
    if (bram_wr_en_d) begin
      bram_wr_addr_d = {victim_q, cur_set, beat_q};
      bram_wr_data_d = mem_rdata_i;
      beat_d         = beat_q + BEAT_BITS'(1);
    end

    if (beat_fire && unc_q) dc_data_d = lane_data;

    if (state_q == TAGW) begin
      rr_d[cur_set] = (rr_q[cur_set] == WAY_BITS'(WAYS - 1)) ? '0
                                                             : rr_q[cur_set] + WAY_BITS'(1);
    end

    mem_req_d   = (state_d == BUSREQ);
    tag_wr_en_d = (state_d == TAGW);
    dc_cmp_d    = (state_d == DONE);
    cooldown_d  = (state_q == DONE);
  end

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      addr_q         <= '0;
      op_q           <= '0;
      unc_q          <= 1'b0;
      victim_q       <= '0;
      beat_q         <= '0;
      // NOTE: the round-robin table is small flop storage, so it is cleared on
      // reset; a RAM-backed table could not be and would need an init sweep.
      rr_q           <= '0;
      cooldown_q     <= 1'b0;
      dc_data_q      <= '0;
      dc_cmp_q       <= 1'b0;
      mem_req_q      <= 1'b0;
      bram_wr_en_q   <= 1'b0;
      bram_wr_addr_q <= '0;
      bram_wr_data_q <= '0;
      tag_wr_en_q    <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      op_q           <= op_d;
      unc_q          <= unc_d;
      victim_q       <= victim_d;
      beat_q         <= beat_d;
      rr_q           <= rr_d;
      cooldown_q     <= cooldown_d;
      dc_data_q      <= dc_data_d;
      dc_cmp_q       <= dc_cmp_d;
      mem_req_q      <= mem_req_d;
      bram_wr_en_q   <= bram_wr_en_d;
      bram_wr_addr_q <= bram_wr_addr_d;
      bram_wr_data_q <= bram_wr_data_d;
      tag_wr_en_q    <= tag_wr_en_d;
    end
  end

  assign dc_data        = dc_data_q;
  assign dc_cmp         = dc_cmp_q;
  assign mem_req_o      = mem_req_q;
  assign mem_addr_o     = unc_q ? {addr_q[31:2], 2'b00}
                                : {addr_q[31:OFF_BITS], {OFF_BITS{1'b0}}};
  assign mem_burst_o    = mem_req_q & ~unc_q;
  assign bram_wr_en_o   = bram_wr_en_q;
  assign bram_wr_addr_o = bram_wr_addr_q;
  assign bram_wr_data_o = bram_wr_data_q;
  assign tag_wr_en_o    = tag_wr_en_q;
  assign tag_wr_set_o   = cur_set;
  assign tag_wr_way_o   = victim_q;
  assign tag_wr_tag_o   = addr_q[OFF_BITS + SET_BITS +: TAG_BITS];

endmodule

// File: tb/tb_dcache_req_responder.sv
// Directed bench for dcache_req_responder: uncached lane extraction, line
// refills with round-robin victims, reset mid-refill, cooldown and stray beats.
module tb_dcache_req_responder;

  logic        core_clock_i = 1'b0;
  logic        core_reset_i = 1'b1;
  logic        dc_req       = 1'b0;
  logic [31:0] dc_addr      = '0;
  logic [1:0]  dc_op        = '0;
  logic        dc_uncached  = 1'b0;
  logic [31:0] dc_data;
  logic        dc_cmp;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_burst_o;
  logic        mem_gnt_i    = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i  = '0;
  logic        bram_wr_en_o;
  logic [10:0] bram_wr_addr_o;
  logic [31:0] bram_wr_data_o;
  logic        tag_wr_en_o;
  logic [4:0]  tag_wr_set_o;
  logic        tag_wr_way_o;
  logic [18:0] tag_wr_tag_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [10:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [4:0]  tag_set_log[$];
  logic        tag_way_log[$];
  logic [18:0] tag_tag_log[$];
  int          wr_at_tag_log[$];
  int          cmp_cnt = 0;

  dcache_req_responder #(.LINE_WORDS(32), .WAYS(2)) dut (
    .core_clock_i   (core_clock_i),
    .core_reset_i   (core_reset_i),
    .dc_req         (dc_req),
    .dc_addr        (dc_addr),
    .dc_op          (dc_op),
    .dc_uncached    (dc_uncached),
    .dc_data        (dc_data),
    .dc_cmp         (dc_cmp),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_burst_o    (mem_burst_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .bram_wr_en_o   (bram_wr_en_o),
    .bram_wr_addr_o (bram_wr_addr_o),
    .bram_wr_data_o (bram_wr_data_o),
    .tag_wr_en_o    (tag_wr_en_o),
    .tag_wr_set_o   (tag_wr_set_o),
    .tag_wr_way_o   (tag_wr_way_o),
    .tag_wr_tag_o   (tag_wr_tag_o)
  );

  always #5 core_clock_i = ~core_clock_i;

  // BRAM writes are logged before tag writes so a same-cycle final beat is counted.
  always @(negedge core_clock_i) begin
    if (bram_wr_en_o) begin
      wr_addr_log.push_back(bram_wr_addr_o);
      wr_data_log.push_back(bram_wr_data_o);
    end
    if (tag_wr_en_o) begin
      tag_set_log.push_back(tag_wr_set_o);
      tag_way_log.push_back(tag_wr_way_o);
      tag_tag_log.push_back(tag_wr_tag_o);
      wr_at_tag_log.push_back(wr_addr_log.size());
    end
    if (dc_cmp) cmp_cnt++;
  end

  task automatic tick();
    @(posedge core_clock_i);
    #1;
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic [1:0] op, input logic unc,
                         input int gnt_delay, input logic [31:0] data_base, input logic hold_req,
                         output logic ok, output logic [31:0] addr_seen,
                         output logic burst_seen, output logic req_held);
    int n;
    int nbeats;
    ok = 1'b1; req_held = 1'b1; addr_seen = '0; burst_seen = 1'b0;
    nbeats = unc ? 1 : 32;
    dc_addr = addr; dc_op = op; dc_uncached = unc; dc_req = 1'b1;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 50) begin tick(); n++; end
    if (mem_req_o !== 1'b1) begin ok = 1'b0; dc_req = 1'b0; return; end
    if (!hold_req) begin
      dc_req = 1'b0; dc_addr = ~addr; dc_uncached = ~unc;
      dc_op = (op == 2'd2) ? 2'd0 : 2'd2;
    end
    repeat (gnt_delay) begin
      tick();
      if (mem_req_o !== 1'b1) req_held = 1'b0;
    end
    addr_seen = mem_addr_o; burst_seen = mem_burst_o;
    mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (unc || (i % 5 == 2)) tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = data_base + 32'(i);
      tick();
      mem_rvalid_i = 1'b0;
    end
    mem_rdata_i = 32'hFFFF_FFFF;
    n = 0;
    while (dc_cmp !== 1'b1 && n < 100) begin tick(); n++; end
    if (dc_cmp !== 1'b1) ok = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    core_reset_i = 1'b1;
    repeat (2) tick();
    tests_run++; if (dc_cmp !== 1'b0) begin tests_failed++; $display("FAIL reset_dc_cmp: got %0b expected 0", dc_cmp); end
    tests_run++; if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req_o); end
    tests_run++; if (mem_burst_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_burst: got %0b expected 0", mem_burst_o); end
    tests_run++; if (bram_wr_en_o !== 1'b0) begin tests_failed++; $display("FAIL reset_bram_wr_en: got %0b expected 0", bram_wr_en_o); end
    tests_run++; if (tag_wr_en_o !== 1'b0) begin tests_failed++; $display("FAIL reset_tag_wr_en: got %0b expected 0", tag_wr_en_o); end
    tests_run++; if (dc_data !== 32'h0) begin tests_failed++; $display("FAIL reset_dc_data: got %h expected 00000000", dc_data); end
    core_reset_i = 1'b0;
    repeat (3) tick();
    tests_run++; if (mem_req_o !== 1'b0 || cmp_cnt != 0) begin tests_failed++; $display("FAIL reset_idle_quiet: got req=%0b cmp=%0d expected 0/0", mem_req_o, cmp_cnt); end
  endtask

  task automatic test_uncached();
    logic [31:0] t_addr [0:5];
    logic [1:0]  t_op   [0:5];
    logic [31:0] t_rd   [0:5];
    logic [31:0] t_ma   [0:5];
    logic [31:0] t_exp  [0:5];
    logic ok, burst, held;
    logic [31:0] ma;
    int cmp0, wr0, tag0;
    t_addr = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0001, 32'h8000_0000, 32'h8000_0104, 32'h8000_0000};
    t_op   = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
    t_rd   = '{32'hAABB_CCDD, 32'h1234_5678, 32'hAABB_CCDD, 32'h1234_5678, 32'hCAFE_F00D, 32'hAABB_CCDD};
    t_ma   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0104, 32'h8000_0000};
    t_exp  = '{32'h0000_00AA, 32'h0000_1234, 32'h0000_00CC, 32'h0000_5678, 32'hCAFE_F00D, 32'h0000_00DD};
    for (int k = 0; k < 6; k++) begin
      cmp0 = cmp_cnt; wr0 = wr_addr_log.size(); tag0 = tag_set_log.size();
      run_txn(t_addr[k], t_op[k], 1'b1, k % 3, t_rd[k], 1'b0, ok, ma, burst, held);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL unc%0d_timeout: got no completion expected dc_cmp", k); end
      tests_run++; if (ma !== t_ma[k]) begin tests_failed++; $display("FAIL unc%0d_mem_addr: got %h expected %h", k, ma, t_ma[k]); end
      tests_run++; if (burst !== 1'b0) begin tests_failed++; $display("FAIL unc%0d_burst: got %0b expected 0", k, burst); end
      tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL unc%0d_req_held: got dropped expected held", k); end
      tests_run++; if (dc_data !== t_exp[k]) begin tests_failed++; $display("FAIL unc%0d_dc_data: got %h expected %h", k, dc_data, t_exp[k]); end
      tests_run++; if (cmp_cnt - cmp0 != 1 || dc_cmp !== 1'b0) begin tests_failed++; $display("FAIL unc%0d_cmp_pulse: got %0d cycles expected 1", k, cmp_cnt - cmp0); end
      tests_run++; if (wr_addr_log.size() != wr0 || tag_set_log.size() != tag0) begin tests_failed++; $display("FAIL unc%0d_no_writes: got %0d bram %0d tag expected 0 0", k, wr_addr_log.size() - wr0, tag_set_log.size() - tag0); end
    end
  endtask

  task automatic do_refill(input string name, input logic [31:0] addr, input logic [31:0] base,
                           input logic [31:0] exp_ma, input logic [10:0] exp_bram,
                           input logic exp_way, input logic [4:0] exp_set,
                           input logic [18:0] exp_tag, input logic [31:0] exp_dc_data);
    logic ok, burst, held;
    logic [31:0] ma;
    int cmp0, wr0, tag0, bad;
    cmp0 = cmp_cnt; wr0 = wr_addr_log.size(); tag0 = tag_set_log.size();
    run_txn(addr, 2'd2, 1'b0, 3, base, 1'b0, ok, ma, burst, held);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL %s_timeout: got no completion expected dc_cmp", name); end
    tests_run++; if (ma !== exp_ma) begin tests_failed++; $display("FAIL %s_mem_addr: got %h expected %h", name, ma, exp_ma); end
    tests_run++; if (burst !== 1'b1) begin tests_failed++; $display("FAIL %s_burst: got %0b expected 1", name, burst); end
    tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL %s_req_held: got dropped expected held", name); end
    tests_run++; if (wr_addr_log.size() - wr0 != 32) begin tests_failed++; $display("FAIL %s_wr_count: got %0d expected 32", name, wr_addr_log.size() - wr0); end
    else begin
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        tests_run++;
        if (wr_addr_log[wr0 + i] !== exp_bram + 11'(i) || wr_data_log[wr0 + i] !== base + 32'(i)) begin
          tests_failed++; bad++;
          if (bad <= 4) $display("FAIL %s_beat%0d: got addr %h data %h expected addr %h data %h", name, i,
                                 wr_addr_log[wr0 + i], wr_data_log[wr0 + i], exp_bram + 11'(i), base + 32'(i));
        end
      end
    end
    tests_run++; if (tag_set_log.size() - tag0 != 1) begin tests_failed++; $display("FAIL %s_tag_count: got %0d expected 1", name, tag_set_log.size() - tag0); end
    else begin
      tests_run++; if (tag_set_log[tag0] !== exp_set) begin tests_failed++; $display("FAIL %s_tag_set: got %h expected %h", name, tag_set_log[tag0], exp_set); end
      tests_run++; if (tag_way_log[tag0] !== exp_way) begin tests_failed++; $display("FAIL %s_tag_way: got %0b expected %0b", name, tag_way_log[tag0], exp_way); end
      tests_run++; if (tag_tag_log[tag0] !== exp_tag) begin tests_failed++; $display("FAIL %s_tag_value: got %h expected %h", name, tag_tag_log[tag0], exp_tag); end
      tests_run++; if (wr_at_tag_log[tag0] != wr0 + 32) begin tests_failed++; $display("FAIL %s_tag_order: got %0d writes before tag expected 32", name, wr_at_tag_log[tag0] - wr0); end
    end
    tests_run++; if (cmp_cnt - cmp0 != 1) begin tests_failed++; $display("FAIL %s_cmp_pulse: got %0d cycles expected 1", name, cmp_cnt - cmp0); end
    tests_run++; if (dc_data !== exp_dc_data) begin tests_failed++; $display("FAIL %s_dc_data_hold: got %h expected %h", name, dc_data, exp_dc_data); end
  endtask

  task automatic test_refill();
    do_refill("refill1", 32'h0000_1A84, 32'h0, 32'h0000_1A80, 11'h2A0, 1'b0, 5'h15, 19'h1, 32'h0000_00DD);
  endtask

  task automatic test_round_robin();
    do_refill("rr_way1", 32'h0000_2A84, 32'h100, 32'h0000_2A80, 11'h6A0, 1'b1, 5'h15, 19'h2, 32'h0000_00DD);
    do_refill("rr_set0", 32'h0000_1004, 32'h180, 32'h0000_1000, 11'h000, 1'b0, 5'h00, 19'h1, 32'h0000_00DD);
    do_refill("rr_way0", 32'h0000_3A80, 32'h200, 32'h0000_3A80, 11'h2A0, 1'b0, 5'h15, 19'h3, 32'h0000_00DD);
  endtask

  task automatic test_reset_mid_refill();
    int n, tag0;
    tag0 = tag_set_log.size();
    dc_addr = 32'h0000_1A84; dc_op = 2'd2; dc_uncached = 1'b0; dc_req = 1'b1;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 50) begin tick(); n++; end
    tests_run++; if (mem_req_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_accept: got req=%0b expected 1", mem_req_o); end
    dc_req = 1'b0;
    mem_gnt_i = 1'b1; tick(); mem_gnt_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0500 + 32'(i);
      tick();
    end
    mem_rvalid_i = 1'b0;
    core_reset_i = 1'b1;
    #1;
    tests_run++; if (bram_wr_en_o !== 1'b0 || mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_async: got wr=%0b req=%0b expected 0/0", bram_wr_en_o, mem_req_o); end
    repeat (2) tick();
    core_reset_i = 1'b0;
    repeat (40) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0600;
      tick();
    end
    mem_rvalid_i = 1'b0;
    tests_run++; if (tag_set_log.size() != tag0) begin tests_failed++; $display("FAIL midrst_no_tag: got %0d tag writes expected 0", tag_set_log.size() - tag0); end
    tests_run++; if (dc_data !== 32'h0) begin tests_failed++; $display("FAIL midrst_dc_data: got %h expected 00000000", dc_data); end
    do_refill("after_rst", 32'h0000_1A84, 32'h300, 32'h0000_1A80, 11'h2A0, 1'b0, 5'h15, 19'h1, 32'h0);
  endtask

  task automatic test_cooldown();
    logic ok, burst, held;
    logic [31:0] ma;
    run_txn(32'h8000_0003, 2'd0, 1'b1, 1, 32'h1122_3344, 1'b1, ok, ma, burst, held);
    tests_run++; if (ok !== 1'b1 || dc_data !== 32'h0000_0011) begin tests_failed++; $display("FAIL cool_txn: got ok=%0b data %h expected 1 00000011", ok, dc_data); end
    tests_run++; if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL cool_cycle1: got req=%0b expected 0", mem_req_o); end
    tick();
    tests_run++; if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL cool_no_accept: got req=%0b expected 0", mem_req_o); end
    tick();
    tests_run++; if (mem_req_o !== 1'b1) begin tests_failed++; $display("FAIL cool_reaccept: got req=%0b expected 1", mem_req_o); end
    dc_req = 1'b0;
    core_reset_i = 1'b1; repeat (2) tick(); core_reset_i = 1'b0; tick();
  endtask

  task automatic test_stray_rvalid();
    int cmp0, wr0, tag0;
    cmp0 = cmp_cnt; wr0 = wr_addr_log.size(); tag0 = tag_set_log.size();
    dc_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_0000 + 32'(i);
      tick();
    end
    mem_rvalid_i = 1'b0;
    tick();
    tests_run++; if (wr_addr_log.size() != wr0 || tag_set_log.size() != tag0) begin tests_failed++; $display("FAIL stray_writes: got %0d bram %0d tag expected 0 0", wr_addr_log.size() - wr0, tag_set_log.size() - tag0); end
    tests_run++; if (dc_data !== 32'h0 || cmp_cnt != cmp0) begin tests_failed++; $display("FAIL stray_capture: got data %h cmp %0d expected 00000000 0", dc_data, cmp_cnt - cmp0); end
    tests_run++; if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL stray_idle: got req=%0b expected 0", mem_req_o); end
  endtask

  initial begin
    test_reset();
    test_uncached();
    test_refill();
    test_round_robin();
    test_reset_mid_refill();
    test_cooldown();
    test_stray_rvalid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_req_responder.md
DCACHE_REQ_RESPONDER -- requirements
Module: dcache_req_responder

Interface
REQ-001 Parameters SHALL be: LINE_WORDS, default 32, meaning 32-bit words per cache line (128 B); WAYS, default 2, meaning data-cache ways.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset; core_clock_i is listed first, then core_reset_i.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- core_clock_i  in  1  core clock.
- core_reset_i  in  1  asynchronous active-high reset.
- dc_req  in  1  request level from the load queue; held until dc_cmp.
- dc_addr  in  32  request address.
- dc_op  in  2  access size: 0 byte, 1 half, 2 word.
- dc_uncached  in  1  1 = single MMIO read; 0 = line refill.
- dc_data  out  32  uncached result, right-justified, zero-filled.
- dc_cmp  out  1  one-cycle completion pulse.
- mem_req_o  out  1  bus request, held until granted.
- mem_addr_o  out  32  bus address.
- mem_burst_o  out  1  1 = LINE_WORDS-beat burst; 0 = single beat.
- mem_gnt_i  in  1  bus accepts the request in this cycle.
- mem_rvalid_i  in  1  read beat valid.
- mem_rdata_i  in  32  read beat data.
- bram_wr_en_o  out  1  data BRAM write strobe.
- bram_wr_addr_o  out  11  {way, addr[11:2]}.
- bram_wr_data_o  out  32  refill word.
- tag_wr_en_o  out  1  tag/valid write strobe.
- tag_wr_set_o  out  5  set index, addr[11:7].
- tag_wr_way_o  out  1  victim way.
- tag_wr_tag_o  out  19  tag, addr[30:12].

Function
REQ-004 The FSM SHALL have the states IDLE, BUSREQ, BEATS, TAGW and DONE.
REQ-005 In IDLE with dc_req=1, the FSM SHALL latch addr, op, uncached and the victim way, then go to BUSREQ the next cycle.
REQ-006 In BUSREQ, mem_req_o SHALL be 1.
- Uncached: mem_addr_o = {dc_addr[31:2], 2'b00}, mem_burst_o = 0.
- Refill: mem_addr_o = {dc_addr[31:7], 7'b0}, mem_burst_o = 1.
- The FSM SHALL stay in BUSREQ until mem_gnt_i=1, then go to BEATS.
REQ-007 In BEATS, uncached: the first mem_rvalid_i SHALL capture the shifted data (REQ-008) into dc_data; the FSM then goes to DONE.
REQ-008 Uncached shifting SHALL be:
- word: dc_data = rdata.
- half: dc_data = {16'b0, addr[1] ? rdata[31:16] : rdata[15:0]}.
- byte: dc_data = {24'b0, the byte selected by addr[1:0]}.
REQ-009 In BEATS, refill: each mem_rvalid_i SHALL write one word the same cycle.
- bram_wr_en_o=1; bram_wr_addr_o = {victim, addr[11:7], beat[4:0]}; bram_wr_data_o = mem_rdata_i.
- The beat counter starts at 0 and increments per valid beat.
- After beat LINE_WORDS-1 the FSM goes to TAGW.
- Cycles without rvalid SHALL cause no write.
REQ-010 TAGW SHALL last one cycle:
- tag_wr_en_o=1 with the latched set, way and tag.
- The victim's per-set round-robin bit toggles.
- The FSM then goes to DONE.
REQ-011 A line's tag SHALL never be written before all of its LINE_WORDS beats are written, so no partial line is ever valid.
REQ-012 DONE SHALL assert dc_cmp=1 for exactly one cycle, then return to IDLE; dc_data SHALL hold its value until the next uncached capture.
REQ-013 The FSM SHALL not accept a new request in the cycle after DONE, even if dc_req is still 1 (one-cycle cooldown).
REQ-014 Mid-operation changes SHALL be ignored:
- dc_req falling mid-operation does not abort; the transaction completes and dc_cmp pulses.
- dc_addr, dc_op and dc_uncached are not re-sampled after IDLE.
REQ-015 mem_rvalid_i outside BEATS SHALL be ignored.
REQ-016 Victim way SHALL be the per-set round-robin bit, latched in IDLE.
REQ-017 dc_cmp, mem_req_o, bram_wr_en_o and tag_wr_en_o SHALL be registered outputs.
REQ-018 The beat counter SHALL be log2(LINE_WORDS) bits wide and wrap to 0 at refill end.

Reset
REQ-019 core_reset_i SHALL asynchronously force:
- state = IDLE;
- dc_cmp, mem_req_o, mem_burst_o, bram_wr_en_o, tag_wr_en_o = 0;
- dc_data = 0; beat counter = 0; all round-robin bits = 0.
REQ-020 Reset during BEATS SHALL drop the transaction; no tag write SHALL occur, so the line stays invalid.

Structure
REQ-021 A shared package SHALL hold:
- the state enum;
- op encodings DC_OP_BYTE/HALF/WORD;
- LINE_WORDS, SET_BITS=5, TAG_BITS=19.
REQ-022 The uncached byte-lane extractor SHALL be one combinational sub-module, dc_lane_extract.

Verification
REQ-023 Uncached byte: dc_addr=0x8000_0003, op=0, bus returns 0xAABBCCDD -> mem_addr_o=0x8000_0000, burst=0; dc_data=0x0000_00AA; one dc_cmp pulse.
REQ-024 Uncached half: dc_addr=0x8000_0002, op=1, data 0x1234_5678 -> dc_data=0x0000_1234.
REQ-025 Refill: dc_addr=0x0000_1A84, gnt after 3 cycles, 32 beats i, with rvalid gaps -> mem_addr_o=0x0000_1A80; 32 BRAM writes at {0, set 0x15, i}; one tag write (set 0x15, way 0, tag 0x1); then dc_cmp.
REQ-026 A second refill to the same set -> way 1; a third -> way 0.
REQ-027 Reset asserted at beat 10 -> no tag write; IDLE; a new request is then accepted normally.
REQ-028 dc_req held high through DONE -> no second acceptance in the cooldown cycle; stray rvalid in IDLE -> no writes.
